// File: rtl/des_input_loader.sv
// des_input_loader: packs 32-bit words into 64-bit DES blocks and key,
// buffers blocks in a 2-entry FIFO and plays them out in fixed slots.
//
// Ports:
//   clk, nrst                       clock, async active-low reset
//   wr_valid/wr_ready/wr_data       32-bit word handshake
//   wr_is_key, mode_in              word type, mode (with 2nd key word)
//   des_enable/des_data/des_key     DES block drive
//   des_encr_decr                   registered mode
//   busy                            loader or DES pipeline active
module des_input_loader #(
    parameter int SLOT_LEN     = 8,
    parameter int DRAIN_CYCLES = 24
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic        wr_is_key,
    input  logic        mode_in,
    output logic        des_enable,
    output logic [63:0] des_data,
    output logic [63:0] des_key,
    output logic        des_encr_decr,
    output logic        busy
);

    localparam int SW = $clog2(SLOT_LEN + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   slot_cnt;
    logic [SW-1:0]   slot_nxt;
    logic [DW-1:0]   drain_cnt;
    logic [DW-1:0]   drain_nxt;
    logic            en_nxt;
    logic            pop;

    logic [63:0]     fifo_mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      fifo_count;

    logic [31:0]     stage;
    logic            half_ptr;
    logic            key_ptr;

    logic            data_rdy;
    logic            key_ok;
    logic            accept;
    logic            push;
    logic            key_wr;

    // Registered state only: a pop in this cycle does not free a slot.
    assign data_rdy = ~half_ptr | (fifo_count != 2'd2);

    assign key_ok = (state == IDLE) & (fifo_count == 2'd0)
                  & (drain_cnt == '0) & ~half_ptr;

    assign wr_ready = wr_is_key ? key_ok : (data_rdy & ~key_ptr);

    assign accept = wr_valid & wr_ready;
    assign push   = accept & ~wr_is_key & half_ptr;
    assign key_wr = accept & wr_is_key;

    assign busy = (state == RUN) | (fifo_count != 2'd0)
                | (drain_cnt != '0) | half_ptr | key_ptr;

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_cnt;
        drain_nxt = drain_cnt;
        en_nxt    = des_enable;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (drain_cnt != '0)
                    drain_nxt = drain_cnt - 1'b1;
                if (fifo_count != 2'd0) begin
                    pop       = 1'b1;
                    en_nxt    = 1'b1;
                    slot_nxt  = '0;
                    drain_nxt = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (slot_cnt == SW'(SLOT_LEN - 1)) begin
                    if (fifo_count != 2'd0) begin
                        pop      = 1'b1;
                        slot_nxt = '0;
                    end else begin
                        en_nxt    = 1'b0;
                        drain_nxt = DW'(DRAIN_CYCLES);
                        state_nxt = IDLE;
                    end
                end else begin
                    slot_nxt = slot_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            slot_cnt   <= '0;
            drain_cnt  <= '0;
            des_enable <= 1'b0;
        end else begin
            state      <= state_nxt;
            slot_cnt   <= slot_nxt;
            drain_cnt  <= drain_nxt;
            des_enable <= en_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            des_data    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {stage, wr_data};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                des_data <= fifo_mem[rd_ptr];
                rd_ptr   <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stage    <= '0;
            half_ptr <= 1'b0;
        end else if (accept & ~wr_is_key) begin
            if (!half_ptr)
                stage <= wr_data;
            half_ptr <= ~half_ptr;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            des_key       <= '0;
            des_encr_decr <= 1'b0;
            key_ptr       <= 1'b0;
        end else if (key_wr) begin
            if (!key_ptr) begin
                des_key[63:32] <= wr_data;
            end else begin
                des_key[31:0]  <= wr_data;
                des_encr_decr  <= mode_in;
            end
            key_ptr <= ~key_ptr;
        end
    end

endmodule

// File: tb/tb_des_input_loader.sv
// tb_des_input_loader: directed bench for des_input_loader.
// Linear steps with immediate assertions against hand-computed values.
module tb_des_input_loader;

    logic        clk;
    logic        nrst;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        wr_is_key;
    logic        mode_in;
    logic        des_enable;
    logic [63:0] des_data;
    logic [63:0] des_key;
    logic        des_encr_decr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    des_input_loader #(
        .SLOT_LEN(8),
        .DRAIN_CYCLES(24)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .wr_is_key(wr_is_key),
        .mode_in(mode_in),
        .des_enable(des_enable),
        .des_data(des_data),
        .des_key(des_key),
        .des_encr_decr(des_encr_decr),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word, wait (bounded) for wr_ready, complete on next edge.
    task automatic put(input logic [31:0] d, input logic k,
                       input logic m, output int waited);
        wr_valid  = 1'b1;
        wr_data   = d;
        wr_is_key = k;
        mode_in   = m;
        waited    = 0;
        @(negedge clk);
        while (!wr_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) begin
            errors++;
            $display("FAIL put_timeout observed wr_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    logic [63:0] blk [4];
    int          w;
    int          stall_idx;
    int          stall_cnt;

    initial begin
        blk[0] = 64'h0000_1111_2222_3333;
        blk[1] = 64'h4444_5555_6666_7777;
        blk[2] = 64'h8888_9999_AAAA_BBBB;
        blk[3] = 64'hCCCC_DDDD_EEEE_FFFF;

        nrst      = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        wr_is_key = 1'b0;
        mode_in   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_en", 64'(des_enable), 64'd0);
        chk("rst_data", des_data, 64'd0);
        chk("rst_key", des_key, 64'd0);
        chk("rst_mode", 64'(des_encr_decr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(wr_ready), 64'd1);
        nrst = 1'b1;
        step();

        // Key load
        put(32'h1334_5779, 1'b1, 1'b0, w);
        chk("key1_hi", 64'(des_key[63:32]), 64'h1334_5779);
        chk("key1_busy", 64'(busy), 64'd1);
        put(32'h9BBC_DFF1, 1'b1, 1'b1, w);
        chk("key_full", des_key, 64'h1334_5779_9BBC_DFF1);
        chk("key_mode", 64'(des_encr_decr), 64'd1);
        chk("key_idle", 64'(busy), 64'd0);

        // Single block
        put(32'h0123_4567, 1'b0, 1'b0, w);
        put(32'h89AB_CDEF, 1'b0, 1'b0, w);
        chk("sb_pre_en", 64'(des_enable), 64'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("sb_en", 64'(des_enable), 64'd1);
            chk("sb_data", des_data, 64'h0123_4567_89AB_CDEF);
            if (i == 3) begin
                wr_is_key = 1'b1;
                #1;
                chk("sb_key_run", 64'(wr_ready), 64'd0);
                wr_is_key = 1'b0;
            end
        end
        step();
        chk("sb_end_en", 64'(des_enable), 64'd0);
        chk("sb_hold", des_data, 64'h0123_4567_89AB_CDEF);
        for (int k = 0; k < 24; k++) begin
            chk("sb_drain_busy", 64'(busy), 64'd1);
            step();
        end
        chk("sb_idle", 64'(busy), 64'd0);

        // Backpressure: four blocks at full rate
        stall_idx = -1;
        stall_cnt = 0;
        fork
            begin
                int wt;
                for (int i = 0; i < 8; i++) begin
                    put(i[0] ? blk[i/2][31:0] : blk[i/2][63:32],
                        1'b0, 1'b0, wt);
                    if (wt > 0) begin
                        stall_idx = i;
                        stall_cnt++;
                    end
                end
            end
            begin
                int t;
                t = 0;
                step();
                while (!des_enable && t < 20) begin
                    t++;
                    step();
                end
                for (int c = 0; c < 32; c++) begin
                    chk("bp_en", 64'(des_enable), 64'd1);
                    chk("bp_data", des_data, blk[c/8]);
                    step();
                end
                chk("bp_end_en", 64'(des_enable), 64'd0);
            end
        join
        chk("bp_stall_idx", 64'(stall_idx), 64'd7);
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd1);

        // Key blocked during drain, accepted once drain reaches zero
        wr_valid  = 1'b1;
        wr_is_key = 1'b1;
        wr_data   = 32'hCAFE_F00D;
        #1;
        chk("kb_ready", 64'(wr_ready), 64'd0);
        put(32'hCAFE_F00D, 1'b1, 1'b0, w);
        chk("kb_wait", 64'(w), 64'd24);
        chk("kb_key", des_key, 64'hCAFE_F00D_9BBC_DFF1);
        put(32'h0BAD_BEEF, 1'b1, 1'b0, w);
        chk("kb_key2", des_key, 64'hCAFE_F00D_0BAD_BEEF);
        chk("kb_mode", 64'(des_encr_decr), 64'd0);

        // Interleave guard
        put(32'h5555_5555, 1'b0, 1'b0, w);
        wr_valid  = 1'b1;
        wr_is_key = 1'b1;
        wr_data   = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ig_key_ready", 64'(wr_ready), 64'd0);
            step();
        end
        chk("ig_key_kept", des_key, 64'hCAFE_F00D_0BAD_BEEF);
        wr_valid = 1'b0;
        put(32'h6666_6666, 1'b0, 1'b0, w);
        step();
        chk("ig_en", 64'(des_enable), 64'd1);
        chk("ig_data", des_data, 64'h5555_5555_6666_6666);

        // Asynchronous reset mid-run
        step();
        #2;
        nrst = 1'b0;
        #1;
        chk("mr_en", 64'(des_enable), 64'd0);
        chk("mr_data", des_data, 64'd0);
        chk("mr_key", des_key, 64'd0);
        chk("mr_mode", 64'(des_encr_decr), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        wr_is_key = 1'b0;
        #1;
        chk("mr_ready", 64'(wr_ready), 64'd1);
        step();
        nrst = 1'b1;
        step();
        step();
        chk("mr_after", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_input_loader.md
# des_input_loader

Upstream feeder for the DES block. It accepts 32-bit words over a valid/ready handshake and assembles them into 64-bit data blocks and a 64-bit key. Blocks are buffered in a 2-entry FIFO and presented to the DES block one per fixed-length slot, with the enable held high. The key and mode may change only once the DES pipeline has drained.

## Interface
Parameters:
- SLOT_LEN, 8: cycles each block is held on des_data; matches the DES half-pipeline round count.
- DRAIN_CYCLES, 24: cycles after the last slot ends before key/mode may change.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- wr_valid  in  1  word present on wr_data.
- wr_ready  out  1  word accepted on an edge where wr_valid & wr_ready.
- wr_data  in  32  word payload.
- wr_is_key  in  1  1 = key word, 0 = data word.
- mode_in  in  1  encrypt/decrypt select, captured with the second key word.
- des_enable  out  1  enable to the DES block.
- des_data  out  64  current block; the first data word occupies [63:32].
- des_key  out  64  key; the first key word occupies [63:32].
- des_encr_decr  out  1  registered mode.
- busy  out  1  loader or pipeline active.

## Operation
- **Data assembly:**
  - half_ptr=0: an accepted data word loads stage[31:0] (upper half) and sets half_ptr=1.
  - half_ptr=1: an accepted data word pushes {stage, wr_data} into the FIFO and clears half_ptr.
- **Data ready:** (half_ptr==0) | (fifo_count<2), computed from registered state only. A same-cycle pop does NOT free space for a push.
- **FIFO:**
  - 2 entries, in-order.
  - Push and pop in the same cycle leave the count unchanged.
  - A push is never attempted when the count is 2, because of the ready rule.
- **Slot FSM, state IDLE:** if fifo_count>0, pop the head into des_data, set des_enable=1 and slot_cnt=0, then go to RUN.
- **Slot FSM, state RUN:** slot_cnt increments every cycle. When slot_cnt==SLOT_LEN-1:
  - FIFO non-empty: pop into des_data, slot_cnt=0, stay in RUN.
  - FIFO empty: des_enable=0, des_data holds, drain_cnt=DRAIN_CYCLES, go to IDLE.
- **Drain:** drain_cnt decrements to 0 in IDLE. If IDLE→RUN occurs while draining, drain_cnt resets to 0; it is reloaded at the next RUN→IDLE.
- **Key path:**
  - key_ok = state IDLE & fifo_count==0 & drain_cnt==0 & half_ptr==0.
  - Key ready = key_ok.
  - First key word loads des_key[63:32] and sets key_ptr. Second key word loads des_key[31:0] and des_encr_decr=mode_in, and clears key_ptr.
  - Data words are refused (wr_ready=0 when wr_is_key=0) while key_ptr==1, so a key load is never interleaved with data.
- **Ready selection:** wr_ready = wr_is_key ? key_ok : (data ready & ~key_ptr).
- **busy:** (state==RUN) | fifo_count>0 | drain_cnt!=0 | half_ptr | key_ptr.

## Timing
- **Reset:** all outputs and state are 0, state=IDLE, FIFO empty, all pointers and counters 0. wr_ready therefore resets to 1.
- **Reset mid-operation:** asynchronous. Drops des_enable immediately, empties the FIFO and discards a partial block or key.
- **Latency:** second data word accepted at edge t, so FIFO push at t. At edge t+1 des_enable=1 and des_data=block.
- **Slot length:** each block is held on des_data for exactly SLOT_LEN cycles.
- **Back-to-back blocks:** consecutive blocks change des_data on consecutive slot boundaries, and des_enable stays high without a gap.
- **End of run:** des_enable falls on the edge ending the last slot. The key becomes writable DRAIN_CYCLES cycles later.
- **Throughput:** a sustained source must supply 2 words per SLOT_LEN cycles. Otherwise a slot boundary finds the FIFO empty and des_enable drops.

## Test plan
- **Reset:** assert nrst=0 mid-run -> des_enable, des_data, des_key, des_encr_decr, busy all 0, and wr_ready=1 with wr_is_key=0.
- **Key load:** key words 0x13345779, 0x9BBCDFF1 with mode_in=1 on an idle loader -> des_key=0x133457799BBCDFF1, des_encr_decr=1.
- **Single block:** data 0x01234567, 0x89ABCDEF -> one cycle after the second word, des_enable=1 and des_data=0x0123456789ABCDEF for 8 cycles. Then des_enable=0, busy=1 for 24 more cycles, then busy=0.
- **Backpressure:** 4 blocks written at full rate -> wr_ready drops when the FIFO holds 2 with half_ptr=1. Blocks appear in order, each for 8 cycles, des_enable stays continuously high for 32 cycles, and no block is lost or duplicated.
- **Key blocked while busy:** attempt a key word during RUN or drain -> wr_ready=0 until drain_cnt hits 0, then the word is accepted and des_key[63:32] updates.
- **Interleave guard:** one data word followed by a key word -> the key word is refused (wr_ready=0). A second data word then completes the block normally.
